// File: rtl/seq_scan_pkg.sv
// Shared types and default sizes for the serial pattern-scan controller.
package seq_scan_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DATA_W_DEF       = 8;
    localparam int DEBOUNCE_CYC_DEF = 16;
    localparam int CNT_W_DEF        = 8;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debounce and a one-cycle
// pulse on each accepted 0->1 change. rst_n is active-high despite its name.
module btn_debounce
    import seq_scan_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic start
);

    localparam int CW = $clog2(DEBOUNCE_CYC);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            start  <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            start <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                cnt    <= '0;
                stable <= ~stable;
                start  <= ~stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan sequencer: clears the detector, streams the latched switch word MSB-first
// and holds the match result on led. Optional SEQ_SCAN_AUTO_EN rescans on switch change.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              button,
    input  logic [DATA_W-1:0] switch,
    input  logic              det_match,
    output logic              det_clr,
    output logic              det_bit,
    output logic              det_valid,
    output logic              busy,
    output logic              done,
    output logic              led,
    output logic [CNT_W-1:0]  scan_count
);

    localparam int IDX_W = $clog2(DATA_W);

    state_t             state;
    state_t             state_nxt;
    logic               start;
    logic               auto_start;
    logic               scan_go;
    logic [DATA_W-1:0]  word;
    logic [IDX_W-1:0]   idx;
    logic               hit;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .button (button),
        .start  (start)
    );

`ifdef SEQ_SCAN_AUTO_EN
    logic [DATA_W-1:0] sw_meta;
    logic [DATA_W-1:0] sw_sync;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

    assign auto_start = (state == DONE) && (sw_sync != word);
`else
    assign auto_start = 1'b0;
`endif

    assign scan_go = start | auto_start;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    // Start requests outside IDLE/DONE fall through the case and are dropped.
    always_comb begin
        state_nxt = state;
        det_clr   = 1'b0;
        det_valid = 1'b0;
        det_bit   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (scan_go) state_nxt = ARM;
            ARM: begin
                det_clr   = 1'b1;
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                det_valid = 1'b1;
                det_bit   = word[idx];
                busy      = 1'b1;
                if (idx == '0) state_nxt = WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (scan_go) state_nxt = ARM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The first SHIFT cycle still shows the match from before the clear, so it is skipped.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            word       <= '0;
            idx        <= '0;
            hit        <= 1'b0;
            led        <= 1'b0;
            scan_count <= '0;
        end else begin
            case (state)
                ARM: begin
                    word <= switch;
                    hit  <= 1'b0;
                    idx  <= IDX_W'(DATA_W - 1);
                end
                SHIFT: begin
                    idx <= idx - 1'b1;
                    if (det_match && (idx != IDX_W'(DATA_W - 1))) hit <= 1'b1;
                end
                WAIT: begin
                    hit        <= hit | det_match;
                    led        <= hit | det_match;
                    scan_count <= scan_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
